// File: rtl/ttt_pkg.sv
// Shared constants and types for the action RAM arbiter: RAM geometry,
// lock state encoding and client indices.
package ttt_pkg;

    localparam int ACTION_ADDR_W = 8;
    localparam int ACTION_DATA_W = 16;

    localparam int CL_MOVE  = 0;
    localparam int CL_TRAIN = 1;

    typedef enum logic [0:0] {
        LK_IDLE,
        LK_LOCKED
    } lk_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. force1 gives requester 1 absolute
// priority and freezes the pointer; advance enables the pointer flip.
module rr_arb2 (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic       force1,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (force1 || ptr) ? 2'b10 : 2'b01;
        end
    end

    // The pointer only moves after a genuine contention decided by round-robin.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= 1'b0;
        end else if (advance && !force1 && req == 2'b11) begin
            ptr <= ~ptr;
        end
    end

endmodule

// File: rtl/action_ram_arbiter.sv
// Arbitrates the action RAM read and write ports between the move selector
// and the trainer, with a trainer address lock. Optional: ACTION_RAM_BYPASS_EN.
module action_ram_arbiter
    import ttt_pkg::*;
#(
    parameter int ADDR_W = ACTION_ADDR_W,
    parameter int DATA_W = ACTION_DATA_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock1,
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_read_address,
    output logic [ADDR_W-1:0] ram_write_address,
    output logic [DATA_W-1:0] ram_d_in,
    output logic              ram_write_enable,
    input  logic [DATA_W-1:0] ram_d_out
);

    lk_state_t         lk_state;
    logic [ADDR_W-1:0] lk_addr;
    logic              locked;
    logic              hit0;
    logic [1:0]        rd_req;
    logic [1:0]        wr_req;
    logic [1:0]        rd_gnt;
    logic [1:0]        wr_gnt;
    logic              rd_any;
    logic              wr_any;
    logic [ADDR_W-1:0] rd_addr_sel;
    logic [ADDR_W-1:0] wr_addr_sel;
    logic [DATA_W-1:0] wr_data_sel;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;

    assign locked = (lk_state == LK_LOCKED);
    assign hit0   = locked && (addr0 == lk_addr);

    // Requests are gated by reset so no grant (and no RAM write) can escape it.
    assign rd_req = {req[CL_TRAIN] & ~we[CL_TRAIN],
                     req[CL_MOVE] & ~we[CL_MOVE] & ~hit0} & {2{reset_n}};
    assign wr_req = {req[CL_TRAIN] & we[CL_TRAIN],
                     req[CL_MOVE] & we[CL_MOVE] & ~hit0} & {2{reset_n}};

    rr_arb2 u_rd_rr (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (rd_req),
        .advance (~locked),
        .force1  (locked),
        .gnt     (rd_gnt)
    );

    rr_arb2 u_wr_rr (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (wr_req),
        .advance (~locked),
        .force1  (locked),
        .gnt     (wr_gnt)
    );

    assign gnt         = rd_gnt | wr_gnt;
    assign rd_any      = |rd_gnt;
    assign wr_any      = |wr_gnt;
    assign rd_addr_sel = rd_gnt[CL_TRAIN] ? addr1 : addr0;
    assign wr_addr_sel = wr_gnt[CL_TRAIN] ? addr1 : addr0;
    assign wr_data_sel = wr_gnt[CL_TRAIN] ? wdata1 : wdata0;

    assign ram_read_address  = rd_any ? rd_addr_sel : rd_addr_q;
    assign ram_write_address = wr_any ? wr_addr_sel : wr_addr_q;
    assign ram_d_in          = wr_any ? wr_data_sel : wr_data_q;
    assign ram_write_enable  = wr_any;

    // Last presented RAM inputs are held so the RAM pins stay quiet when idle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rvalid    <= 2'b00;
        end else begin
            if (rd_any) begin
                rd_addr_q <= rd_addr_sel;
            end
            if (wr_any) begin
                wr_addr_q <= wr_addr_sel;
                wr_data_q <= wr_data_sel;
            end
            rvalid <= rd_gnt;
        end
    end

`ifdef ACTION_RAM_BYPASS_EN
    logic              byp_flag;
    logic [DATA_W-1:0] byp_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            byp_flag <= 1'b0;
            byp_data <= '0;
        end else begin
            byp_flag <= rd_any && wr_any && (rd_addr_sel == wr_addr_sel);
            byp_data <= wr_data_sel;
        end
    end

    assign rdata = byp_flag ? byp_data : ram_d_out;
`else
    assign rdata = ram_d_out;
`endif

    // Lock held from a locking trainer read until the trainer writes the
    // locked address back or abandons the lock while idle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lk_state <= LK_IDLE;
            lk_addr  <= '0;
        end else begin
            case (lk_state)
                LK_IDLE: begin
                    if (rd_gnt[CL_TRAIN] && lock1) begin
                        lk_state <= LK_LOCKED;
                        lk_addr  <= addr1;
                    end
                end
                LK_LOCKED: begin
                    if ((wr_gnt[CL_TRAIN] && addr1 == lk_addr) ||
                        (!lock1 && !req[CL_TRAIN])) begin
                        lk_state <= LK_IDLE;
                    end
                end
                default: lk_state <= LK_IDLE;
            endcase
        end
    end

endmodule

// File: doc/action_ram_arbiter.md
# action_ram_arbiter

Shares the 256×16 action RAM between two clients: the move selector (client 0), which reads action values during play, and the trainer (client 1), which reads and rewrites them during learning. The RAM's independent read and write ports are arbitrated separately, so one read and one write proceed in the same cycle. A lock lets the trainer hold a read-modify-write sequence on one address without interference. The block sits directly in front of `action_ram` and drives all of its address, data and enable inputs.

## Interface
- `ADDR_W`, 8: RAM address width.
- `DATA_W`, 16: RAM data width.
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req[1:0]`  in  2  per-client request valid.
- `we[1:0]`  in  2  per-client op: 1 = write, 0 = read.
- `addr0`, `addr1`  in  ADDR_W  per-client address.
- `wdata0`, `wdata1`  in  DATA_W  per-client write data.
- `lock1`  in  1  trainer lock request; sampled on a granted trainer read.
- `gnt[1:0]`  out  2  per-client accept, combinational; the request completes in the cycle where `req & gnt` are both high.
- `rvalid[1:0]`  out  2  read data valid, registered.
- `rdata`  out  DATA_W  read data, shared by both clients; qualify with `rvalid`.
- `ram_read_address`, `ram_write_address`  out  ADDR_W  to RAM.
- `ram_d_in`  out  DATA_W  to RAM.
- `ram_write_enable`  out  1  to RAM.
- `ram_d_out`  in  DATA_W  from RAM; synchronous read, valid one cycle after the address is presented.

## Operation
- **Read arbitration.** Among the clients with `req & ~we`:
  - a single requester is granted;
  - if both request, the one selected by round-robin pointer `rd_rr` is granted; `rd_rr` then flips to the other client.
- **Write arbitration.** Same rule using an independent pointer `wr_rr`.
- **Concurrent read and write.** A read and a write from different clients are both granted in the same cycle.
- **Idle outputs.** `ram_write_enable` is 1 only in a cycle with a granted write. Addresses and `ram_d_in` hold their last values when idle.
- **Lock FSM.** States are IDLE and LOCKED.
  - IDLE → LOCKED on a granted trainer read with `lock1=1`. The locked address is captured in `lk_addr`.
  - In LOCKED, client 0 is refused any read or write whose address equals `lk_addr` (`gnt[0]=0`). Client 0 accesses to other addresses arbitrate normally.
  - In LOCKED, trainer requests always win arbitration. The pointers do not advance in this case.
  - LOCKED → IDLE on a granted trainer write to `lk_addr`, or when `lock1` is deasserted while `req[1]=0`.
- **Read-during-write to the same address in the same cycle.** Without the bypass (see Configuration), the read returns the old data.
- **Handshake rules.**
  - A client holds `req`, `we`, `addr` and `wdata` stable until it sees `gnt`.
  - `gnt` is never asserted without `req`.
  - Each client has at most one read outstanding. `rvalid` follows the grant by exactly one cycle, so no throttling is needed.

## Timing
- Read latency is 1 cycle: a grant in cycle N gives `rvalid` and `rdata` = `ram_d_out` in cycle N+1.
- Write latency: a grant in cycle N means the RAM is written on the edge that ends cycle N.
- Reset values:
  - `rvalid=0`, `rd_rr=0`, `wr_rr=0`, FSM in IDLE, `lk_addr=0`.
  - `ram_write_enable=0`, because reset forces the grants low.
  - `ram_read_address=0`, `ram_write_address=0`, `ram_d_in=0`.
- Reset asserted mid-lock: the FSM returns to IDLE immediately, and any `rvalid` in flight is dropped.
- Back-to-back grants to the same client are allowed every cycle.

## Configuration
- `ACTION_RAM_BYPASS_EN` defined:
  - A same-cycle granted read and write to the same address returns `wdata` of the writer on `rdata` in the next cycle.
  - Implementation: a registered bypass flag plus the captured data.
- `ACTION_RAM_BYPASS_EN` undefined: such a read returns the pre-write RAM contents.

## Structure
- Shared package `ttt_pkg` holds:
  - `ACTION_ADDR_W = 8` and `ACTION_DATA_W = 16`;
  - the lock state enum `{LK_IDLE, LK_LOCKED}`;
  - the client index constants `CL_MOVE = 0` and `CL_TRAIN = 1`.
- One sub-module, `rr_arb2`: a 2-requester round-robin arbiter with an `advance` input and a `force1` override. It is instantiated twice, once for reads and once for writes.

## Test plan
- **Reads through the shared path.** Preload `0x20..0x23` with `2..5`. Client 0 reads `0x20..0x23` on consecutive cycles → `gnt[0]` every cycle; `rvalid[0]` one cycle later; `rdata` = `2, 3, 4, 5`.
- **Read fairness.** Both clients read continuously for 6 cycles → grants alternate 0, 1, 0, 1, 0, 1 starting from client 0 after reset; each `rvalid` lands at the matching owner.
- **Concurrent read and write.** Client 0 writes `0x10` = `0x0007` while client 1 reads `0x11` → both granted in the same cycle; a later read of `0x10` returns `0x0007`.
- **Lock.** Trainer reads `0x30` with `lock1=1`.
  - Client 0 then requests `0x30` → `gnt[0]=0` until the trainer writes `0x30` = `0x0009`.
  - Next cycle client 0 is granted and reads `0x0009`.
  - A client 0 read of `0x31` during the lock is granted.
- **Same-address read and write in one cycle.** `0x40` holds `0x0001`; client 1 writes `0x40` = `0x0002` while client 0 reads `0x40` → `rdata` = `0x0001` without `ACTION_RAM_BYPASS_EN`, `0x0002` with it.
- **Reset mid-lock.** `reset_n` pulsed low while LOCKED with a read in flight → `rvalid=0` and both pointers 0 immediately; client 0 can access `lk_addr` right after reset releases.
